// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcode constants, FSM state
// encoding, instruction field bit positions and a small opcode classifier.
// Both the sequencer top and the ALU import this package, so the opcode
// values used for decoding and for selecting the ALU operation cannot drift
// apart.
package alu_sequencer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 8;

  // Instruction word layout.
  // Register-form instructions use rd/rs/rt. LDI uses rd plus imm10.
  // imm10 overlaps rs/rt; the opcode decides which interpretation applies.
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned RD_MSB  = 12;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_MSB  = 9;
  localparam int unsigned RS_LSB  = 7;
  localparam int unsigned RT_MSB  = 6;
  localparam int unsigned RT_LSB  = 4;
  localparam int unsigned IMM_MSB = 9;
  localparam int unsigned IMM_LSB = 0;

  // Encodings 3'b110 and 3'b111 are deliberately left unnamed.
  // Instructions that carry them are rejected as illegal.
  typedef enum logic [2:0] {
    ADD_OP    = 3'b000,
    SUB_OP    = 3'b001,
    NAND_OP   = 3'b010,
    PASS_A_OP = 3'b011,
    PASS_B_OP = 3'b100,
    LDI_OP    = 3'b101
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_e;

  // ALU opcodes are the contiguous range ADD_OP..PASS_B_OP.
  function automatic logic is_alu_op(input logic [2:0] opc);
    return opc <= PASS_B_OP;
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// alu: 16-bit combinational ALU.
// Ports:
//   op_select - operation; it uses the same encoding as the instruction opcode.
//   a         - first operand.
//   b         - second operand.
//   result    - operation result, taken modulo 2^16.
// There are no carry or overflow outputs.
module alu
  import alu_sequencer_pkg::*;
(
  input  logic [2:0]        op_select,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  // NOTE: combinational blocks assign every output a default first, so that
  // no path through the case statement can infer a latch.
  always_comb begin
    result = '0;
    case (op_select)
      ADD_OP:    result = a + b;
      SUB_OP:    result = a - b;
      NAND_OP:   result = ~(a & b);
      PASS_A_OP: result = a;
      PASS_B_OP: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: executes one 16-bit instruction at a time against an
// 8 x 16-bit register bank.
// An ALU instruction passes through IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// LDI skips EXECUTE.
// An illegal opcode returns from DECODE straight to IDLE.
// Ports:
//   clk, rst          - clock; asynchronous active-high reset.
//   instr_valid/ready - instruction handshake. instr_ready is high only in IDLE.
//   instr             - instruction word, sampled on the transfer edge.
//   busy              - high whenever the FSM is not in IDLE.
//   done              - one-cycle pulse in the WRITEBACK cycle.
//   illegal           - one-cycle pulse when an illegal opcode reaches DECODE.
//   zero              - high when the last written-back value was zero.
//   dbg_addr/dbg_data - combinational read port into the register bank.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic [DATA_W-1:0] REG_RESET_VAL = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              zero,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, result_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              zero_q;
  logic [DATA_W-1:0] alu_result;

  logic [2:0] opc, rd, rs, rt;
  logic [9:0] imm;

  assign opc = instr_q[OPC_MSB:OPC_LSB];
  assign rd  = instr_q[RD_MSB:RD_LSB];
  assign rs  = instr_q[RS_MSB:RS_LSB];
  assign rt  = instr_q[RT_MSB:RT_LSB];
  assign imm = instr_q[IMM_MSB:IMM_LSB];

  alu u_alu (
    .op_select (opc),
    .a         (op_a_q),
    .b         (op_b_q),
    .result    (alu_result)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  // Every register then samples the pre-edge values, which is what lets rs,
  // rt and rd alias safely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = DECODE;
      end
      DECODE: begin
        if (is_alu_op(opc))     state_d = EXECUTE;
        else if (opc == LDI_OP) state_d = WRITEBACK;
        else begin
          illegal = 1'b1;
          state_d = IDLE;
        end
      end
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: the register bank has only eight entries and must come out of
  // reset holding REG_RESET_VAL, so it is built from flops with an
  // asynchronous reset rather than mapped to a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= REG_RESET_VAL;
    end else begin
      case (state_q)
        IDLE: if (instr_valid) instr_q <= instr;
        DECODE: begin
          if (is_alu_op(opc)) begin
            op_a_q <= regs_q[rs];
            op_b_q <= regs_q[rt];
          end else if (opc == LDI_OP) begin
            result_q <= {6'b0, imm};
          end
        end
        EXECUTE: result_q <= alu_result;
        WRITEBACK: begin
          regs_q[rd] <= result_q;
          zero_q     <= (result_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign zero     = zero_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer.
// A behavioural register-bank model computes the expected register contents
// and zero flag. Timing is summarised as a signature:
//   done_count*1000 + first_done_cycle*100 + illegal_count*10 + first_ready_cycle
// Cycles are counted from the transfer edge; -1 means the handshake timed out.
module tb_alu_sequencer;

  localparam logic [15:0] RST_VAL = 16'h0000;
  localparam int SIG_ALU = 1304;
  localparam int SIG_LDI = 1203;
  localparam int SIG_ILL = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        busy, done, illegal, zero;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_regs [8];
  logic        m_zero;
  logic [15:0] bank [8];

  alu_sequencer #(.REG_RESET_VAL(RST_VAL)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .zero        (zero),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc_alu(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [9:0] imm);
    return {3'b101, rd, imm};
  endfunction

  function automatic int exp_sig(input logic [2:0] op);
    if (op <= 3'd4) return SIG_ALU;
    if (op == 3'd5) return SIG_LDI;
    return SIG_ILL;
  endfunction

  // Reference arithmetic, computed with integer math and reduced modulo 65536.
  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int r;
    case (op)
      3'd0:    r = (int'(a) + int'(b)) % 65536;
      3'd1:    r = (int'(a) - int'(b) + 65536) % 65536;
      3'd2:    r = 65535 - int'(a & b);
      3'd3:    r = int'(a);
      default: r = int'(b);
    endcase
    return r[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = RST_VAL;
    m_zero = 1'b0;
  endtask

  task automatic model_apply(input logic [15:0] w);
    logic [2:0] op, rd;
    op = w[15:13];
    rd = w[12:10];
    if (op <= 3'd4) begin
      m_regs[rd] = ref_alu(op, m_regs[w[9:7]], m_regs[w[6:4]]);
      m_zero     = (m_regs[rd] == 16'h0000);
    end else if (op == 3'd5) begin
      m_regs[rd] = {6'b0, w[9:0]};
      m_zero     = (m_regs[rd] == 16'h0000);
    end
  endtask

  task automatic snap_bank();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      bank[i] = dbg_data;
    end
  endtask

  // Present w, wait (bounded) for acceptance, then watch the following six
  // cycles and return the timing signature.
  task automatic issue(input logic [15:0] w, output int sig, output int waited);
    int done_k, done_n, ill_n, ready_k;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    waited      = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      instr_valid = 1'b0;
      sig         = -1;
      return;
    end
    @(posedge clk);
    done_k = 0; done_n = 0; ill_n = 0; ready_k = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      if (done) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (illegal) ill_n++;
      if (instr_ready && ready_k == 0) ready_k = k;
    end
    sig = done_n * 1000 + done_k * 100 + ill_n * 10 + ready_k;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({instr_ready, busy, done, illegal, zero} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy/busy/done/ill/zero=%b want 10000",
               {instr_ready, busy, done, illegal, zero});
    end
    snap_bank();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bank[i] !== RST_VAL) begin
        n_bad++;
        $display("FAIL reset_reg R%0d got %h want %h", i, bank[i], RST_VAL);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ldi();
    int sig, w;
    issue(enc_ldi(3'd1, 10'h005), sig, w);
    model_apply(enc_ldi(3'd1, 10'h005));
    n_cmp++;
    if (sig !== SIG_LDI) begin
      n_bad++;
      $display("FAIL ldi_r1_timing got %0d want %0d", sig, SIG_LDI);
    end
    issue(enc_ldi(3'd2, 10'h003), sig, w);
    model_apply(enc_ldi(3'd2, 10'h003));
    n_cmp++;
    if (sig !== SIG_LDI) begin
      n_bad++;
      $display("FAIL ldi_r2_timing got %0d want %0d", sig, SIG_LDI);
    end
    snap_bank();
    n_cmp++;
    if ({bank[1], bank[2]} !== {16'h0005, 16'h0003}) begin
      n_bad++;
      $display("FAIL ldi_values got R1=%h R2=%h want 0005 0003", bank[1], bank[2]);
    end
  endtask

  task automatic test_alu_ops();
    int sig, w;
    issue(enc_alu(3'd0, 3'd3, 3'd1, 3'd2), sig, w);
    snap_bank();
    n_cmp++;
    if ({sig, bank[3], zero} !== {SIG_ALU, 16'h0008, 1'b0}) begin
      n_bad++;
      $display("FAIL add_r3 got sig=%0d R3=%h zero=%b want %0d 0008 0", sig, bank[3], zero, SIG_ALU);
    end
    issue(enc_alu(3'd1, 3'd4, 3'd2, 3'd2), sig, w);
    snap_bank();
    n_cmp++;
    if ({sig, bank[4], zero} !== {SIG_ALU, 16'h0000, 1'b1}) begin
      n_bad++;
      $display("FAIL sub_r4 got sig=%0d R4=%h zero=%b want %0d 0000 1", sig, bank[4], zero, SIG_ALU);
    end
    model_apply(enc_alu(3'd0, 3'd3, 3'd1, 3'd2));
    model_apply(enc_alu(3'd1, 3'd4, 3'd2, 3'd2));
  endtask

  task automatic test_nand_alias();
    int sig, w;
    logic [15:0] seq [4];
    seq[0] = enc_ldi(3'd5, 10'h3FF);
    seq[1] = enc_alu(3'd2, 3'd6, 3'd5, 3'd5);
    seq[2] = enc_ldi(3'd7, 10'h001);
    seq[3] = enc_alu(3'd0, 3'd7, 3'd7, 3'd7);
    for (int i = 0; i < 4; i++) begin
      issue(seq[i], sig, w);
      model_apply(seq[i]);
    end
    snap_bank();
    n_cmp++;
    if ({bank[6], bank[7]} !== {16'hFC00, 16'h0002}) begin
      n_bad++;
      $display("FAIL nand_alias got R6=%h R7=%h want FC00 0002", bank[6], bank[7]);
    end
  endtask

  task automatic test_wrap();
    int sig, w;
    issue(enc_ldi(3'd1, 10'h000), sig, w);
    issue(enc_ldi(3'd2, 10'h001), sig, w);
    issue(enc_alu(3'd1, 3'd3, 3'd1, 3'd2), sig, w);
    model_apply(enc_ldi(3'd1, 10'h000));
    model_apply(enc_ldi(3'd2, 10'h001));
    model_apply(enc_alu(3'd1, 3'd3, 3'd1, 3'd2));
    snap_bank();
    n_cmp++;
    if ({bank[3], zero} !== {16'hFFFF, 1'b0}) begin
      n_bad++;
      $display("FAIL sub_wrap got R3=%h zero=%b want FFFF 0", bank[3], zero);
    end
  endtask

  task automatic test_illegal();
    int sig, w;
    issue(16'hC123, sig, w);
    n_cmp++;
    if (sig !== SIG_ILL) begin
      n_bad++;
      $display("FAIL illegal_timing got %0d want %0d", sig, SIG_ILL);
    end
    snap_bank();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bank[i] !== m_regs[i]) begin
        n_bad++;
        $display("FAIL illegal_reg R%0d got %h want %h", i, bank[i], m_regs[i]);
      end
    end
    n_cmp++;
    if (zero !== m_zero) begin
      n_bad++;
      $display("FAIL illegal_zero got %b want %b", zero, m_zero);
    end
  endtask

  // instr_valid stays high across an illegal instruction followed by an LDI.
  // The LDI must be taken only when instr_ready returns in cycle N+2, so its
  // done pulse must land in cycle N+4.
  task automatic test_back_to_back();
    int done_k = 0, done_n = 0, ill_n = 0, ready_k = 0, waited = 0, sig;
    logic [15:0] w2;
    w2 = enc_ldi(3'd1, 10'h2A5);
    @(negedge clk);
    instr       = 16'hE000;
    instr_valid = 1'b1;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) instr = w2;
      if (k == 3) instr_valid = 1'b0;
      if (done) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (illegal) ill_n++;
      if (instr_ready && ready_k == 0) ready_k = k;
    end
    instr_valid = 1'b0;
    sig = done_n * 1000 + done_k * 100 + ill_n * 10 + ready_k;
    n_cmp++;
    if (sig !== 1412) begin
      n_bad++;
      $display("FAIL back_to_back_timing got %0d want 1412", sig);
    end
    model_apply(w2);
    snap_bank();
    n_cmp++;
    if (bank[1] !== m_regs[1]) begin
      n_bad++;
      $display("FAIL back_to_back_r1 got %h want %h", bank[1], m_regs[1]);
    end
  endtask

  task automatic test_random();
    int sig, w;
    logic [15:0] word;
    for (int n = 0; n < 40; n++) begin
      word = 16'($urandom);
      issue(word, sig, w);
      model_apply(word);
      snap_bank();
      n_cmp++;
      if (sig !== exp_sig(word[15:13])) begin
        n_bad++;
        $display("FAIL rand%0d_timing instr=%h got %0d want %0d", n, word, sig, exp_sig(word[15:13]));
      end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (bank[i] !== m_regs[i]) begin
          n_bad++;
          $display("FAIL rand%0d_reg instr=%h R%0d got %h want %h", n, word, i, bank[i], m_regs[i]);
        end
      end
      n_cmp++;
      if (zero !== m_zero) begin
        n_bad++;
        $display("FAIL rand%0d_zero instr=%h got %b want %b", n, word, zero, m_zero);
      end
    end
  endtask

  task automatic test_reset_mid();
    int sig, waited = 0, done_n = 0;
    test_reset();
    issue(enc_ldi(3'd1, 10'h005), sig, waited);
    issue(enc_ldi(3'd2, 10'h003), sig, waited);
    waited = 0;
    @(negedge clk);
    instr       = enc_alu(3'd0, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    // Cycle N+1 is DECODE and cycle N+2 is EXECUTE.
    // Reset is asserted in the middle of EXECUTE.
    @(negedge clk);
    instr_valid = 1'b0;
    if (done) done_n++;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_busy_before got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({instr_ready, busy, done, illegal, zero} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_mid_async got rdy/busy/done/ill/zero=%b want 10000",
               {instr_ready, busy, done, illegal, zero});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    n_cmp++;
    if ({done_n, instr_ready} !== {32'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_abort got done_pulses=%0d ready=%b want 0 1", done_n, instr_ready);
    end
    snap_bank();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bank[i] !== RST_VAL) begin
        n_bad++;
        $display("FAIL reset_mid_reg R%0d got %h want %h", i, bank[i], RST_VAL);
      end
    end
  endtask

  // The first instruction after reset release must be taken without waiting.
  task automatic test_after_reset();
    int sig, waited;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    issue(enc_ldi(3'd0, 10'h1C3), sig, waited);
    model_apply(enc_ldi(3'd0, 10'h1C3));
    snap_bank();
    n_cmp++;
    if ({waited, sig, bank[0]} !== {32'd0, SIG_LDI, 16'h01C3}) begin
      n_bad++;
      $display("FAIL after_reset got waited=%0d sig=%0d R0=%h want 0 %0d 01C3", waited, sig, bank[0], SIG_LDI);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ldi();
    test_alu_ops();
    test_nand_alias();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
